wdt: RTL

//  Watchdog core on the MMIO bus at core prefix 6'h05, behind the CPU memory decode mux.

---
 rtl/wdt.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wdt.sv
// Watchdog core on the MMIO bus (core prefix 6'h05).
// Firmware starts it through CTRL and must write the KICK magic value
// before TIMEOUT ticks elapse; a missed or corrupted kick latches the
// EXPIRED state and raises wdt_reset_req until reset_n is asserted.
// Optional build macro: WDT_LOCK_EN - once running, CTRL writes are ignored
// so the watchdog cannot be stopped; STATUS bit2 reports the lock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | stopped; PRESCALER/TIMEOUT writable, kicks ignored
// RUN     | counting ticks down; needs periodic valid kicks
// EXPIRED | timeout or bad kick; reset request held until reset_n
module wdt #(
  parameter logic [31:0] PRESCALER_RST = 32'd18000,
  parameter logic [31:0] TIMEOUT_RST   = 32'd1000,
  parameter logic [31:0] KICK_MAGIC    = 32'h4b49434b
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        running,
  output logic        wdt_reset_req
);

  localparam logic [7:0] ADDR_NAME0     = 8'h00;
  localparam logic [7:0] ADDR_NAME1     = 8'h01;
  localparam logic [7:0] ADDR_VERSION   = 8'h02;
  localparam logic [7:0] ADDR_CTRL      = 8'h08;
  localparam logic [7:0] ADDR_STATUS    = 8'h09;
  localparam logic [7:0] ADDR_PRESCALER = 8'h0a;
  localparam logic [7:0] ADDR_TIMEOUT   = 8'h0b;
  localparam logic [7:0] ADDR_KICK      = 8'h0c;
  localparam logic [7:0] ADDR_COUNT     = 8'h0d;

  localparam logic [31:0] CORE_NAME0   = 32'h746b3120; // "tk1 "
  localparam logic [31:0] CORE_NAME1   = 32'h77647420; // "wdt "
  localparam logic [31:0] CORE_VERSION = 32'h00000001;

`ifdef WDT_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_prescaler, w_prescaler_nxt;
  logic [31:0] r_timeout,   w_timeout_nxt;
  logic [31:0] r_cnt,       w_cnt_nxt;
  logic [31:0] r_pre_cnt,   w_pre_cnt_nxt;

  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_kick_wr;
  logic        w_expired;
  logic        w_locked;
  logic [31:0] w_rdata;

  assign w_wr      = cs & we;
  assign w_ctrl_wr = w_wr & (address == ADDR_CTRL);
  assign w_kick_wr = w_wr & (address == ADDR_KICK);
  assign w_expired = (r_state == S_EXPIRED);
  assign w_locked  = LOCK_EN & (r_state == S_RUN);

  // State and counter registers; everything returns to reset values at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_prescaler <= PRESCALER_RST;
      r_timeout   <= TIMEOUT_RST;
      r_cnt       <= TIMEOUT_RST;
      r_pre_cnt   <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_prescaler <= w_prescaler_nxt;
      r_timeout   <= w_timeout_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pre_cnt   <= w_pre_cnt_nxt;
    end
  end

  // Next-state logic: bus writes, prescaler ticks and timeout detection
  always_comb begin
    w_state_nxt     = r_state;
    w_prescaler_nxt = r_prescaler;
    w_timeout_nxt   = r_timeout;
    w_cnt_nxt       = r_cnt;
    w_pre_cnt_nxt   = r_pre_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_wr && address == ADDR_PRESCALER)
          w_prescaler_nxt = write_data;
        if (w_wr && address == ADDR_TIMEOUT)
          w_timeout_nxt = (write_data == 32'd0) ? 32'd1 : write_data;
        if (w_ctrl_wr && write_data[0]) begin
          w_state_nxt   = S_RUN;
          w_cnt_nxt     = r_timeout;
          w_pre_cnt_nxt = r_prescaler;
        end
      end
      S_RUN: begin
        // Stop beats a kick or tick in the same cycle; a kick beats the tick.
        if (w_ctrl_wr && !write_data[0] && !LOCK_EN) begin
          w_state_nxt = S_IDLE;
        end else if (w_kick_wr) begin
          if (write_data == KICK_MAGIC) begin
            w_cnt_nxt     = r_timeout;
            w_pre_cnt_nxt = r_prescaler;
          end else begin
            w_state_nxt = S_EXPIRED;
          end
        end else if (r_pre_cnt == 32'd0) begin
          w_pre_cnt_nxt = r_prescaler;
          // cnt is never 0 in RUN; <= 1 keeps the counter from wrapping anyway
          if (r_cnt <= 32'd1) begin
            w_state_nxt = S_EXPIRED;
            w_cnt_nxt   = 32'd0;
          end else begin
            w_cnt_nxt = r_cnt - 32'd1;
          end
        end else begin
          w_pre_cnt_nxt = r_pre_cnt - 32'd1;
        end
      end
      S_EXPIRED: begin
        w_state_nxt = S_EXPIRED;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Combinational register read mux; zero when not selected or unmapped
  always_comb begin
    w_rdata = 32'd0;
    if (cs) begin
      case (address)
        ADDR_NAME0:     w_rdata = CORE_NAME0;
        ADDR_NAME1:     w_rdata = CORE_NAME1;
        ADDR_VERSION:   w_rdata = CORE_VERSION;
        ADDR_CTRL:      w_rdata = {31'd0, running};
        ADDR_STATUS:    w_rdata = {29'd0, w_locked, w_expired, running};
        ADDR_PRESCALER: w_rdata = r_prescaler;
        ADDR_TIMEOUT:   w_rdata = r_timeout;
        ADDR_COUNT:     w_rdata = r_cnt;
        default:        w_rdata = 32'd0;
      endcase
    end
  end

  assign read_data     = w_rdata;
  assign ready         = cs;
  assign running       = (r_state == S_RUN);
  assign wdt_reset_req = w_expired;

endmodule
